// File: rtl/regread_arbiter.sv
// -----------------------------------------------------------------------------
// regread_arbiter
//
// Arbitrates NREQ requesters onto a single 32-entry register read mux.
// The granted requester's address is driven onto ctrl_read in the issue
// cycle, and the mux data (rd_data) comes back registered one cycle later,
// tagged with a one-hot rsp_valid strobe.
//
// Arbitration is round-robin from a rotating pointer. A granted requester
// that also holds lock takes the bus exclusively for a burst of up to
// MAX_BURST consecutive grants. The burst ends when it drops lock or when
// the burst limit is reached.
//
// Optional build macro:
//   REGREAD_ARB_FIXED_PRIO_EN - when defined, the ARB state grants the
//   lowest-index requester instead of using the round-robin pointer.
//   Locked bursts behave the same in both builds.
//
// Ports:
//   clock         rising-edge clock
//   ctrl_reset_n  asynchronous active-low reset
//   req[NREQ]     per-requester read request, held until granted
//   lock[NREQ]    per-requester burst-lock request, sampled with req
//   addr[5*NREQ]  register address per requester, slice i = [5i+4:5i]
//   gnt[NREQ]     one-hot grant, combinational
//   ctrl_read[5]  read mux select (address of the granted requester, else 0)
//   rd_data[32]   read mux data for ctrl_read, same cycle
//   rsp_valid     one-hot registered response strobe
//   rsp_data[32]  registered read data accompanying rsp_valid
// -----------------------------------------------------------------------------
module regread_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [5*NREQ-1:0] addr,
    output logic [NREQ-1:0]   gnt,
    output logic [4:0]        ctrl_read,
    input  logic [31:0]       rd_data,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   owner, owner_nxt;
    logic [3:0]      burst_cnt, burst_cnt_nxt;
    logic [3:0]      cnt_inc;
    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [4:0]      addr_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_addr
        assign addr_arr[g] = addr[5*g +: 5];
    end

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        if (int'(i) == NREQ - 1) return '0;
        return i + PW'(1);
    endfunction

    // Grant selection
    always_comb begin
        int unsigned j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (state == LOCKED) begin
            gnt_any = req[owner];
            gnt_idx = owner;
        end else begin
`ifdef REGREAD_ARB_FIXED_PRIO_EN
            // Scan downwards so the lowest requesting index wins last.
            for (int unsigned k = NREQ; k > 0; k--) begin
                if (req[PW'(k - 1)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PW'(k - 1);
                end
            end
`else
            for (int unsigned k = 0; k < NREQ; k++) begin
                j = int'(ptr) + k;
                if (j >= unsigned'(NREQ)) j = j - unsigned'(NREQ);
                if (!gnt_any && req[PW'(j)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PW'(j);
                end
            end
`endif
        end
        // Nothing is issued while reset is held.
        if (!ctrl_reset_n) gnt_any = 1'b0;
    end

    always_comb begin
        gnt       = '0;
        ctrl_read = 5'd0;
        if (gnt_any) begin
            gnt       = NREQ'(1) << gnt_idx;
            ctrl_read = addr_arr[gnt_idx];
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        cnt_inc       = burst_cnt + 4'd1;
        if (state == ARB) begin
            if (gnt_any) begin
                ptr_nxt = wrap_inc(gnt_idx);
                // With MAX_BURST == 1 the opening grant is already the whole
                // burst, so there is no LOCKED phase to enter.
                if (lock[gnt_idx] && MAX_BURST > 1) begin
                    state_nxt     = LOCKED;
                    owner_nxt     = gnt_idx;
                    burst_cnt_nxt = 4'd1;
                end
            end
        end else begin
            if (gnt_any) burst_cnt_nxt = cnt_inc;
            // burst_cnt counts grants already issued in the burst. The limit
            // is reached when this cycle's grant brings it to MAX_BURST.
            if (!lock[owner] || (gnt_any && cnt_inc == 4'(MAX_BURST))) begin
                state_nxt     = ARB;
                ptr_nxt       = wrap_inc(owner);
                burst_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state     <= ARB;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
            rsp_valid <= gnt;
            if (gnt_any) rsp_data <= rd_data;
        end
    end

endmodule

// File: tb/tb_regread_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regread_arbiter
//
// Self-checking bench for regread_arbiter with NREQ=4 and MAX_BURST=8.
// The bench runs directed sequences first and then randomized traffic.
// All DUT outputs are compared against a behavioural model of the
// arbitration rules. Define REGREAD_ARB_FIXED_PRIO_EN here too when building
// the fixed-priority variant.
// -----------------------------------------------------------------------------
module tb_regread_arbiter;

    localparam int N  = 4;
    localparam int MB = 8;
    localparam int AW = 5 * N;

    logic          clock = 1'b0;
    logic          ctrl_reset_n;
    logic [N-1:0]  req;
    logic [N-1:0]  lock;
    logic [AW-1:0] addr;
    logic [N-1:0]  gnt;
    logic [4:0]    ctrl_read;
    logic [31:0]   rd_data;
    logic [N-1:0]  rsp_valid;
    logic [31:0]   rsp_data;

    regread_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
        .clock       (clock),
        .ctrl_reset_n(ctrl_reset_n),
        .req         (req),
        .lock        (lock),
        .addr        (addr),
        .gnt         (gnt),
        .ctrl_read   (ctrl_read),
        .rd_data     (rd_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           m_locked;
    int           m_ptr;
    int           m_owner;
    int           m_cnt;
    logic [N-1:0] m_rv;
    logic [31:0]  m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_ptr    = 0;
        m_owner  = 0;
        m_cnt    = 0;
        m_rv     = '0;
        m_rd     = '0;
    endtask

    function automatic int pick(input logic [N-1:0] r);
        if (m_locked) return r[m_owner] ? m_owner : -1;
`ifdef REGREAD_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 0; k < N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    // One clock cycle: drive inputs, check against the model, then advance the model.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic [AW-1:0] a, input logic [31:0] rd,
                        output logic [N-1:0] g_obs);
        int         g;
        logic [4:0] exp_cr;
        req = r; lock = l; addr = a; rd_data = rd;
        #2;
        g      = pick(r);
        exp_cr = (g >= 0) ? a[5*g +: 5] : 5'd0;
        check("gnt",       32'(gnt), (g >= 0) ? (32'(1) << g) : 32'd0);
        check("ctrl_read", 32'(ctrl_read), 32'(exp_cr));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        check("rsp_data",  rsp_data, m_rd);
        g_obs = gnt;
        @(posedge clock);
        m_rv = (g >= 0) ? (N'(1) << g) : '0;
        if (g >= 0) m_rd = rd;
        if (!m_locked) begin
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (l[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                    m_cnt    = 1;
                end
            end
        end else begin
            if (g >= 0) m_cnt++;
            if (!l[m_owner]) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end
        end
        if (m_locked && m_cnt == MB) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % N;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        ctrl_reset_n = 1'b0;
        req = '1; lock = '0; addr = '1; rd_data = 32'hFFFF_FFFF;
        #2;
        check("rst_gnt",       32'(gnt), 32'd0);
        check("rst_ctrl_read", 32'(ctrl_read), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  rsp_data, 32'd0);
        @(posedge clock);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [N-1:0]  g;
        logic [N-1:0]  r;
        logic [N-1:0]  l;
        logic [N-1:0]  pending;
        logic [AW-1:0] a;

        ctrl_reset_n = 1'b0;
        req = '0; lock = '0; addr = '0; rd_data = '0;
        model_reset();
        @(negedge clock);
        do_reset();

        // Single read: address 7, data DEADBEEF
        a = '0; a[4:0] = 5'd7;
        step(4'b0001, 4'b0000, a, 32'hDEADBEEF, g);
        check("d030_gnt", 32'(g), 32'h1);
        #2;
        check("d030_rsp_valid", 32'(rsp_valid), 32'h1);
        check("d030_rsp_data",  rsp_data, 32'hDEADBEEF);
        step(4'b0000, 4'b0000, a, 32'h0, g);

        // All requesting, no lock
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'b0000, AW'($urandom), $urandom, g);
`ifdef REGREAD_ARB_FIXED_PRIO_EN
            check("d031_gnt", 32'(g), 32'h1);
`else
            check("d031_gnt", 32'(g), 32'(1) << (i % 4));
`endif
        end

        // Requester 2 locks for a full burst of MB grants
        do_reset();
        step(4'b0100, 4'b0100, AW'($urandom), $urandom, g);
        check("d032_gnt", 32'(g), 32'h4);
        for (int i = 1; i < MB; i++) begin
            step(4'b1111, 4'b0100, AW'($urandom), $urandom, g);
            check("d032_gnt", 32'(g), 32'h4);
        end
        step(4'b1111, 4'b0100, AW'($urandom), $urandom, g);
`ifdef REGREAD_ARB_FIXED_PRIO_EN
        check("d032_after", 32'(g), 32'h1);
`else
        check("d032_after", 32'(g), 32'h8);
`endif

        // Owner 1 drops lock after 3 grants
        do_reset();
        step(4'b0001, 4'b0000, AW'($urandom), $urandom, g);
        step(4'b0010, 4'b0010, AW'($urandom), $urandom, g);
        check("d033_lock", 32'(g), 32'h2);
        step(4'b1111, 4'b0010, AW'($urandom), $urandom, g);
        check("d033_burst", 32'(g), 32'h2);
        step(4'b1111, 4'b0010, AW'($urandom), $urandom, g);
        check("d033_burst", 32'(g), 32'h2);
        step(4'b1101, 4'b0000, AW'($urandom), $urandom, g);
        check("d033_drop", 32'(g), 32'h0);
        step(4'b1111, 4'b0000, AW'($urandom), $urandom, g);
`ifdef REGREAD_ARB_FIXED_PRIO_EN
        check("d033_after", 32'(g), 32'h1);
`else
        check("d033_after", 32'(g), 32'h4);
`endif

        // Reset asserted during an issue cycle discards the response
        step(4'b0001, 4'b0000, AW'($urandom), 32'h12345678, g);
        req = 4'b0100; lock = '0; rd_data = 32'hCAFEF00D;
        #2;
        check("d034_issue", 32'(gnt), 32'h4);
        #1;
        ctrl_reset_n = 1'b0;
        #1;
        check("d034_gnt_in_rst", 32'(gnt), 32'h0);
        check("d034_rsp_cleared", rsp_data, 32'h0);
        @(posedge clock);
        #2;
        check("d034_rsp_valid", 32'(rsp_valid), 32'h0);
        check("d034_rsp_data",  rsp_data, 32'h0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        model_reset();
        step(4'b1111, 4'b0000, AW'($urandom), $urandom, g);
        check("d034_ptr0", 32'(g), 32'h1);

        // Randomized traffic: requests stay up until granted
        do_reset();
        pending = '0;
        for (int n = 0; n < 400; n++) begin
            r = pending | N'($urandom);
            for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 3) != 0);
            step(r, l, AW'($urandom), $urandom, g);
            pending = r & ~g;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regread_arbiter.md
REGREAD_ARBITER -- requirements
Module: regread_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter MAX_BURST, default 8, giving the maximum consecutive locked grants (1..15).
REQ-003 Port clock  input  1  single clock; all state changes on the rising edge.
REQ-004 Port ctrl_reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  NREQ  per-requester read request, held until granted.
REQ-006 Port lock  input  NREQ  per-requester burst-lock request, sampled with req.
REQ-007 Port addr  input  5*NREQ  register address per requester; slice i is bits [5i+4:5i].
REQ-008 Port gnt  output  NREQ  one-hot grant, combinational, valid in the issue cycle.
REQ-009 Port ctrl_read  output  5  select driven to the 32-entry register read mux.
REQ-010 Port rd_data  input  32  data returned by the read mux for ctrl_read, same cycle.
REQ-011 Port rsp_valid  output  NREQ  one-hot registered response strobe.
REQ-012 Port rsp_data  output  32  registered read data accompanying rsp_valid.

Function
REQ-013 Per cycle, at most one gnt bit SHALL be high, and only for a requester with req high.
REQ-014 In state ARB, the grant SHALL go round-robin: search starts at pointer ptr and takes the first requester with req high, wrapping from NREQ-1 to 0.
REQ-015 ctrl_read SHALL equal addr of the granted requester; with no grant, ctrl_read SHALL be 5'd0.
REQ-016 A grant issued in cycle N SHALL produce rsp_valid[i]=1 and rsp_data=rd_data(N) in cycle N+1, for exactly one cycle. Latency is 1 and throughput is one read per cycle.
REQ-017 With no grant in cycle N, rsp_valid SHALL be all zero in N+1, and rsp_data SHALL hold its previous value.
REQ-018 After a grant to i in ARB, ptr SHALL become (i+1) mod NREQ. With no grant, ptr SHALL be unchanged.
REQ-019 FSM states SHALL be ARB and LOCKED.
REQ-020 ARB->LOCKED SHALL occur when the granted requester i has lock[i]=1. The owner is set to i and burst_cnt to 1.
REQ-021 In LOCKED, only the owner SHALL be granted. Each granted cycle increments burst_cnt. Cycles where the owner's req=0 issue no grant and keep the state.
REQ-022 LOCKED->ARB SHALL occur at the clock edge ending a cycle in which any of these holds:
  - lock[owner]=0
  - the owner is granted with burst_cnt=MAX_BURST
  When it occurs, ptr SHALL become (owner+1) mod NREQ.
REQ-023 A lock asserted by a requester that is not granted SHALL have no effect.
REQ-024 Changes to req, lock or addr by a requester while it is not granted SHALL have no effect on the arbiter state.

Reset
REQ-025 Asserting ctrl_reset_n low SHALL immediately force:
  - state=ARB, ptr=0, owner=0, burst_cnt=0
  - rsp_valid=0, rsp_data=0
REQ-026 A response pending at reset assertion SHALL be discarded and SHALL never appear after reset.
REQ-027 While reset is low, gnt SHALL be 0 and ctrl_read SHALL be 5'd0.
REQ-028 The first grant after release SHALL be possible on the first rising edge with ctrl_reset_n high.

Configuration
REQ-029 Macro REGREAD_ARB_FIXED_PRIO_EN:
  - When defined, ARB grants the lowest-index requesting requester, ptr is not used, and LOCKED behaviour is unchanged.
  - When undefined, round-robin per REQ-014/REQ-018 applies.

Verification
REQ-030 Reset, then req=4'b0001, addr0=5'd7, rd_data=32'hDEADBEEF -> gnt=0001 and ctrl_read=7 in cycle N; rsp_valid=0001 and rsp_data=DEADBEEF in N+1.
REQ-031 req=4'b1111 held for 8 cycles, ptr=0 -> gnt sequence 0001,0010,0100,1000, repeated twice (under REGREAD_ARB_FIXED_PRIO_EN: 0001 for all 8 cycles).
REQ-032 Requester 2 holds req=1 and lock=1 with MAX_BURST=8, others requesting -> gnt=0100 for 8 cycles, then FSM returns to ARB and the next grant goes to requester 3.
REQ-033 In LOCKED with owner 1, lock[1] drops after 3 grants -> FSM returns to ARB at that edge and the next grant goes to requester 2.
REQ-034 Grant issued in cycle N, ctrl_reset_n pulsed low mid-cycle N -> rsp_valid=0 in N+1, rsp_data=0, ptr=0.
